// File: rtl/lane_mem_ctrl.sv
// lane_mem_ctrl: warp-wide load/store responder for the 16-lane SIMT core.
// A request carries an active-lane mask, per-lane addresses and store data,
// and one opcode. The active lanes are serviced one by one against a
// single-ported word memory. All load data comes back together in one
// response beat.
//
// Handshake: a transfer happens on a clk edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge. The
// consumer may drive ready independently of valid. Requests are taken only in
// IDLE. A response, once valid, is held stable until it is accepted.
//
// Optional build macro LANE_MEM_CTRL_COALESCE_EN: each SERVE cycle services,
// as one group, every pending lane whose address matches the address of the
// lowest pending lane. Without the macro, one lane is serviced per cycle.
module lane_mem_ctrl #(
  parameter int LANES     = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_lw_or_sw,
  input  logic [LANES-1:0]         req_mask,
  input  logic [LANES*ADDR_W-1:0]  req_addr,
  input  logic [LANES*DATA_W-1:0]  req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LANES*DATA_W-1:0]  resp_data,
  output logic [LANES-1:0]         resp_mask,
  output logic [LANES-1:0]         resp_err,
  output logic                     busy
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  // Depth widened by one bit so the range compare also works when MEM_DEPTH
  // equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_X = MEM_DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                    state;
  logic                      op_q;       // 1 = load, 0 = store
  logic [LANES-1:0]          pending;
  logic [LANES*ADDR_W-1:0]   addr_q;
  logic [LANES*DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]         mem [MEM_DEPTH];

  logic [ADDR_W-1:0]         addr_l  [LANES];
  logic [DATA_W-1:0]         wdata_l [LANES];
  logic [LANE_W-1:0]         lo_idx;
  logic [ADDR_W-1:0]         lo_addr;
  logic [LANES-1:0]          grp;
  logic [DATA_W-1:0]         st_word;
  logic [DATA_W-1:0]         ld_word;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;

  // Unpack the latched request into per-lane views
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      addr_l[i]  = addr_q[i*ADDR_W +: ADDR_W];
      wdata_l[i] = wdata_q[i*DATA_W +: DATA_W];
    end
  end

  // Pick the lowest pending lane, build this cycle's service group and the
  // word that the group loads or stores
  always_comb begin
    lo_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pending[i]) lo_idx = LANE_W'(i);
    end
    lo_addr = addr_l[lo_idx];
    grp     = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef LANE_MEM_CTRL_COALESCE_EN
      grp[i] = pending[i] && (addr_l[i] == lo_addr);
`else
      grp[i] = pending[i] && (LANE_W'(i) == lo_idx);
`endif
    end
    // Scanning upward means the highest-index lane in the group supplies the
    // store data, which matches servicing the lanes one by one in order.
    st_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (grp[i]) st_word = wdata_l[i];
    end
    // The range check uses the full address. Only the low bits index the array.
    in_range = ({1'b0, lo_addr} < DEPTH_X);
    idx      = lo_addr[IDX_W-1:0];
    ld_word  = in_range ? mem[idx] : '0;
  end

  // Control FSM with registered outputs, plus the memory array and its clear on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      pending    <= '0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_mask  <= '0;
      resp_err   <= '0;
      busy       <= 1'b0;
      for (int m = 0; m < MEM_DEPTH; m++) begin
        mem[IDX_W'(m)] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op_q      <= req_lw_or_sw;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            pending   <= req_mask;
            resp_data <= '0;
            resp_err  <= '0;
            resp_mask <= req_mask;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (req_mask == '0) ? RESP : SERVE;
          end
        end
        SERVE: begin
          if (pending == '0) begin
            // All lanes done on the previous edge; present the response
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            pending <= pending & ~grp;
            for (int i = 0; i < LANES; i++) begin
              if (grp[i]) begin
                if (!in_range) resp_err[i] <= 1'b1;
                else if (op_q) resp_data[i*DATA_W +: DATA_W] <= ld_word;
              end
            end
            if (in_range && !op_q) mem[idx] <= st_word;
          end
        end
        RESP: begin
          if (!resp_valid) begin
            // Empty-mask path: the response appears one edge after accept
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lane_mem_ctrl.md
Name: lane_mem_ctrl

Overview:
- Memory-side responder for the per-lane load/store units of the 16-lane SIMT core.
- Accepts one warp-wide request per handshake. The request carries an active-lane mask, per-lane addresses, per-lane store data and a single load/store opcode.
- Serializes the active lanes onto a single-ported internal word memory and returns all load data together in one response beat.
- Replaces the lane-0-only path into data memory.

Parameters:
- LANES, 16, number of lanes served per request.
- DATA_W, 16, word width.
- ADDR_W, 16, per-lane address width.
- MEM_DEPTH, 256, words of internal storage; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_lw_or_sw  in  1  opcode: 1 = load, 0 = store (same encoding as the LSU).
- req_mask  in  LANES  active lanes.
- req_addr  in  LANES*ADDR_W  lane i address at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  LANES*DATA_W  lane i store data, same packing.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  LANES*DATA_W  lane i load data; 0 for inactive lanes and for stores.
- resp_mask  out  LANES  copy of the accepted req_mask.
- resp_err  out  LANES  lane i address was out of range.
- busy  out  1  high in SERVE or RESP.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - State goes to IDLE; pending mask is cleared.
  - Outputs: req_ready = 0 during reset; resp_valid = 0, resp_data = 0, resp_mask = 0, resp_err = 0, busy = 0.
  - All MEM_DEPTH memory words are cleared to 0.
  - Reset in SERVE or RESP abandons the request; stores already performed remain until the clear completes in the same edge. Effective result: memory is all 0.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch the opcode, mask, addresses and wdata; pending <= req_mask; clear the response registers.
  - If req_mask == 0, go directly to RESP. Otherwise go to SERVE.
- SERVE:
  - req_ready = 0.
  - Each cycle, service the lowest-index pending lane i and clear pending[i].
  - Load: resp_data lane i <= mem[addr_i], read asynchronously and registered.
  - Store: mem[addr_i] <= wdata_i at this edge.
  - Out of range: a load returns 0, a store is dropped, and resp_err[i] <= 1. The lane still consumes one cycle.
  - When the last pending bit clears, go to RESP on the next edge.
  - Latency: with N active lanes, resp_valid rises N+1 edges after the accept edge.
- RESP:
  - resp_valid = 1 and response outputs are held stable until resp_ready.
  - On resp_valid && resp_ready: go to IDLE, where req_ready = 1 on the next cycle. No accept happens in the same cycle as the response handshake.
- Same-address stores within one request: the higher-index lane wins, because it is serviced later.
- Address width: only addr % 2^clog2(MEM_DEPTH) indexes the array after the range check passes. The range check uses the full ADDR_W value.
- req_* inputs are ignored outside IDLE.
- resp_* outputs retain their values in IDLE until the next accept.

Optional Feature:
- Macro: LANE_MEM_CTRL_COALESCE_EN.
- Defined:
  - Each SERVE cycle, every pending lane whose address equals that of the lowest-index pending lane is serviced together and cleared.
  - Loads broadcast the same word to all matched lanes.
  - Stores write the wdata of the highest-index lane in the group.
  - Out-of-range groups all flag resp_err.
  - Latency becomes (number of distinct addresses among active lanes) + 1.
- Undefined: one lane per cycle, exactly as in SERVE above.

Test Plan:
- Store then load:
  - Store, mask 0xFFFF, lane i addr = i, wdata = 0x100+i; response after 17 cycles, resp_err = 0.
  - Load, same addresses; resp_data lane i = 0x100+i, resp_mask = 0xFFFF.
- Sparse mask:
  - Load with mask 0x8001, lanes 0/15 addr 3/4 holding 0xAAAA/0x5555.
  - resp_valid 3 edges after accept; lane0 = 0xAAAA, lane15 = 0x5555, all other lanes 0.
- Empty mask and backpressure:
  - Mask 0 gives resp_valid on the edge after accept.
  - Hold resp_ready = 0 for 5 cycles; outputs stay stable and req_ready stays 0.
  - Raise resp_ready; req_ready returns to 1 on the next cycle.
- Collision and range:
  - Store, mask 0x0007, all addr 10, wdata 1/2/3, then load addr 10 gives 3.
  - Store to addr 300 gives resp_err bit set, memory unchanged, and a load of 300 returns 0.
- Reset mid-SERVE:
  - Assert reset during the 5th cycle of a 16-lane store.
  - busy = 0, resp_valid = 0, req_ready = 1 after release, and a load of any address returns 0.
- Coalescing (macro defined):
  - 16-lane load with all addresses 7 (mem[7] = 0x1234) gives resp_valid 2 edges after accept, with all lanes = 0x1234.
  - Undefined: 17 edges.
